// File: rtl/shift_serializer_tx_pkg.sv
// Shared definitions for the serializer: FSM state encoding and the select codes
// it has in common with universal_shift_register.
package shift_serializer_tx_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SEL_HOLD = 2'b00,
      SEL_SHL  = 2'b01,
      SEL_SHR  = 2'b10,
      SEL_LOAD = 2'b11
   } sel_t;

   // MSB-first words leave from the top, so the register moves left; LSB-first moves right.
   function automatic sel_t out_dir(input bit msb_first);
      return msb_first ? SEL_SHL : SEL_SHR;
   endfunction

endpackage

// File: rtl/shift_hold_buf.sv
// One-word holding register in front of the shifter, with its full flag and
// a pi_ready that depends only on registered state.
module shift_hold_buf #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pi,
   input  logic             pi_valid,
   input  logic             take,
   output logic [WIDTH-1:0] hold_word,
   output logic             hold_full,
   output logic             pi_ready
);

   logic accept;

   assign pi_ready = !hold_full;
   assign accept   = pi_valid && pi_ready;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_full <= 1'b0;
      end else if (accept) begin
         hold_full <= 1'b1;
      end else if (take) begin
         hold_full <= 1'b0;
      end
   end

   // NOTE: the data register is not reset; hold_full alone says whether it is meaningful.
   always_ff @(posedge clk) begin
      if (accept) begin
         hold_word <= pi;
      end
   end

   // Accept needs an empty buffer and take needs a full one, so they never coincide.
   a_no_conflict : assert property (@(posedge clk) disable iff (rst) !(accept && take));
   a_take_full   : assert property (@(posedge clk) disable iff (rst) take |-> hold_full);

endmodule

// File: rtl/shift_serializer_tx.sv
// Parallel-in / serial-out transmitter: one buffered word, gapless streaming,
// per-bit valid with first/last markers.
module shift_serializer_tx
   import shift_serializer_tx_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] PI,
   input  logic             pi_valid,
   output logic             pi_ready,
   output logic             SO,
   output logic             so_valid,
   output logic             so_first,
   output logic             so_last,
   output logic             busy
);

   localparam int               CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
   localparam sel_t             SHIFT_DIR = out_dir(MSB_FIRST);

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] hold_word;
   logic             hold_full;
   logic             last_bit;
   logic             take;
   sel_t             sel;

   shift_hold_buf #(.WIDTH(WIDTH)) u_hold (
      .clk       (clk),
      .rst       (rst),
      .pi        (PI),
      .pi_valid  (pi_valid),
      .take      (take),
      .hold_word (hold_word),
      .hold_full (hold_full),
      .pi_ready  (pi_ready)
   );

   assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST_CNT);

   // A buffered word is loaded whenever the shifter is free or finishing its last bit.
   // NOTE: sel gets a default first so no path through this block infers a latch.
   always_comb begin
      sel = SEL_HOLD;
      if (state == ST_IDLE) begin
         if (hold_full) begin
            sel = SEL_LOAD;
         end
      end else if (last_bit && hold_full) begin
         sel = SEL_LOAD;
      end else begin
         sel = SHIFT_DIR;
      end
   end

   assign take = (sel == SEL_LOAD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else begin
         case (sel)
            SEL_LOAD: shift_reg <= hold_word;
            SEL_SHL:  shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            SEL_SHR:  shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
            default:  shift_reg <= shift_reg;
         endcase

         case (state)
            ST_IDLE: begin
               if (hold_full) begin
                  bit_cnt <= '0;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (last_bit) begin
                  bit_cnt <= '0;
                  if (!hold_full) begin
                     state <= ST_IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               bit_cnt <= '0;
            end
         endcase
      end
   end

   // Outputs decode registered state only; idle forces SO low.
   assign so_valid = (state == ST_SHIFT);
   assign SO       = so_valid && (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
   assign so_first = so_valid && (bit_cnt == '0);
   assign so_last  = last_bit;
   assign busy     = so_valid || hold_full;

   a_cnt_range : assert property (@(posedge clk) disable iff (rst) bit_cnt <= LAST_CNT);

endmodule
